maria_bus_arbiter: RTL and testbench

Sequences ownership of the 7800 system bus between the 6502 (Sally) CPU and the Maria DMA engine. It generates the CPU halt request, waits for the CPU to reach a safe cycle boundary, grants the bus to DMA, and returns the bus with a clean turnaround. It also owns the WSYNC ready-stall. It sits inside the Maria top level, between the clock generator (mclk0/pclk strobes), the DMA engine and the CPU control pins.

---
 rtl/maria_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_maria_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maria_bus_arbiter.sv
// Bus ownership sequencer between the 6502 CPU and the Maria DMA engine, plus the WSYNC ready-stall.
// Optional grant watchdog enabled by defining MARIA_ARB_WATCHDOG_EN.
module maria_bus_arbiter #(
   parameter int WDOG_LIMIT = 454,
   parameter int CNT_W      = 9
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             mclk0,
   input  logic             pclk0,
   input  logic             pclk1,
   input  logic             maria_en,
   input  logic             dma_req,
   input  logic             dma_done,
   input  logic             wsync,
   input  logic             lrc,
   output logic             dma_grant,
   output logic             drive_AB,
   output logic             halt_n,
   output logic             ready,
   output logic [CNT_W-1:0] grant_count,
   output logic             wdog_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      HALT_REQ,
      HALT_WAIT,
      GRANT,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   logic   wdog_fire;
   logic   counting;

   assign counting = (state == GRANT) && mclk0;

`ifdef MARIA_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_LIMIT + 1);
   logic [WD_W-1:0] wdog_cnt;

   assign wdog_fire = counting && maria_en && (wdog_cnt == WD_W'(WDOG_LIMIT - 1));

   // Holding the timer at zero outside GRANT gives the clear-on-entry behaviour.
   always_ff @(posedge clk_sys) begin
      if (reset || state != GRANT) wdog_cnt <= '0;
      else if (mclk0)              wdog_cnt <= wdog_cnt + 1'b1;
   end
`else
   // A negative limit is meaningless, so this is always 0 and keeps the parameter referenced.
   assign wdog_fire = (WDOG_LIMIT < 0);
`endif

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
   always_ff @(posedge clk_sys) begin
      if (reset || !maria_en) begin
         state        <= IDLE;
         dma_grant    <= 1'b0;
         drive_AB     <= 1'b0;
         halt_n       <= 1'b1;
         wdog_timeout <= 1'b0;
      end else begin
         wdog_timeout <= wdog_fire;
         case (state)
            IDLE: begin
               halt_n    <= 1'b1;
               dma_grant <= 1'b0;
               drive_AB  <= 1'b0;
               if (dma_req) state <= HALT_REQ;
            end
            HALT_REQ: begin
               if (!dma_req) state <= IDLE;
               else if (pclk1) begin
                  halt_n <= 1'b0;
                  state  <= HALT_WAIT;
               end
            end
            HALT_WAIT: begin
               // Withdrawal after halt_n fell still needs a pclk1 to lift halt cleanly.
               if (!dma_req) state <= RELEASE;
               else if (pclk0) begin
                  dma_grant <= 1'b1;
                  drive_AB  <= 1'b1;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (dma_done || !dma_req || wdog_fire) begin
                  dma_grant <= 1'b0;
                  drive_AB  <= 1'b0;
                  state     <= RELEASE;
               end
            end
            RELEASE: begin
               if (pclk1) begin
                  halt_n <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || !maria_en) ready <= 1'b1;
      else if (wsync)         ready <= 1'b0;
      else if (lrc)           ready <= 1'b1;
   end

   // Counter freezes entirely while Maria is disabled.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         grant_count <= '0;
      end else if (maria_en) begin
         if (lrc)                                   grant_count <= counting ? CNT_W'(1) : '0;
         else if (counting && grant_count != CNT_MAX) grant_count <= grant_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Self-checking bench for maria_bus_arbiter: directed steps, then random traffic against a flag-based model.
module tb_maria_bus_arbiter;

   localparam int CNT_W      = 9;
   localparam int WDOG_LIMIT = 454;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic clk_sys = 1'b0;
   logic reset, mclk0, pclk0, pclk1, maria_en, dma_req, dma_done, wsync, lrc;
   logic dma_grant, drive_AB, halt_n, ready, wdog_timeout;
   logic [CNT_W-1:0] grant_count;

   int compared   = 0;
   int mismatched = 0;

   // Model: the CPU/bus situation described by independent facts rather than a state number.
   bit m_pending;   // request noticed, waiting for a pclk1 to halt the CPU
   bit m_halt;      // halt_n is expected low
   bit m_own;       // DMA owns the bus
   bit m_return;    // bus given back, waiting for pclk1 to un-halt
   bit m_ready;
   bit m_wd_pulse;
   int m_cnt;
   int m_wd;

   always #5 clk_sys = ~clk_sys;

   maria_bus_arbiter #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .mclk0       (mclk0),
      .pclk0       (pclk0),
      .pclk1       (pclk1),
      .maria_en    (maria_en),
      .dma_req     (dma_req),
      .dma_done    (dma_done),
      .wsync       (wsync),
      .lrc         (lrc),
      .dma_grant   (dma_grant),
      .drive_AB    (drive_AB),
      .halt_n      (halt_n),
      .ready       (ready),
      .grant_count (grant_count),
      .wdog_timeout(wdog_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit fire;
      fire = 1'b0;
      if (reset) begin
         {m_pending, m_halt, m_own, m_return, m_wd_pulse} = '0;
         m_ready = 1'b1;
         m_cnt   = 0;
         m_wd    = 0;
         return;
      end
      if (!maria_en) begin
         {m_pending, m_halt, m_own, m_return, m_wd_pulse} = '0;
         m_ready = 1'b1;
         m_wd    = 0;
         return;
      end
      if (lrc)                                     m_cnt = (m_own && mclk0) ? 1 : 0;
      else if (m_own && mclk0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (wsync)    m_ready = 1'b0;
      else if (lrc) m_ready = 1'b1;
`ifdef MARIA_ARB_WATCHDOG_EN
      if (m_own && mclk0) begin
         m_wd = m_wd + 1;
         fire = (m_wd == WDOG_LIMIT);
      end
`endif
      m_wd_pulse = fire;
      if (m_own) begin
         if (dma_done || !dma_req || fire) begin
            m_own    = 1'b0;
            m_return = 1'b1;
         end
      end else if (m_return) begin
         if (pclk1) begin
            m_return = 1'b0;
            m_halt   = 1'b0;
         end
      end else if (m_halt) begin
         if (!dma_req) m_return = 1'b1;
         else if (pclk0) begin
            m_own = 1'b1;
            m_wd  = 0;
         end
      end else if (m_pending) begin
         if (!dma_req) m_pending = 1'b0;
         else if (pclk1) begin
            m_pending = 1'b0;
            m_halt    = 1'b1;
         end
      end else if (dma_req) begin
         m_pending = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      model_step();
      #1;
      check("halt_n",       32'(halt_n),       32'(!m_halt));
      check("dma_grant",    32'(dma_grant),    32'(m_own));
      check("drive_AB",     32'(drive_AB),     32'(m_own));
      check("ready",        32'(ready),        32'(m_ready));
      check("grant_count",  32'(grant_count),  32'(m_cnt));
      check("wdog_timeout", 32'(wdog_timeout), 32'(m_wd_pulse));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic enter_grant();
      dma_req = 1'b1;
      tick();
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      pclk0 = 1'b1; tick(); pclk0 = 1'b0;
   endtask

   task automatic leave_grant();
      mclk0 = 1'b0;
      dma_req = 1'b0;
      tick();
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      tick();
   endtask

   initial begin
      {mclk0, pclk0, pclk1, dma_req, dma_done, wsync, lrc} = '0;
      maria_en = 1'b1;
      reset    = 1'b1;
      idle(2);
      reset = 1'b0;
      check("rst_halt_n",    32'(halt_n),       32'd1);
      check("rst_ready",     32'(ready),        32'd1);
      check("rst_dma_grant", 32'(dma_grant),    32'd0);
      check("rst_drive_AB",  32'(drive_AB),     32'd0);
      check("rst_count",     32'(grant_count),  32'd0);
      check("rst_wdog",      32'(wdog_timeout), 32'd0);

      // Basic grant and release.
      dma_req = 1'b1;
      idle(4);
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      check("basic_halt_low", 32'(halt_n), 32'd0);
      check("basic_no_grant", 32'(dma_grant), 32'd0);
      idle(3);
      pclk0 = 1'b1; tick(); pclk0 = 1'b0;
      check("basic_grant", 32'(dma_grant), 32'd1);
      check("basic_drive", 32'(drive_AB), 32'd1);
      mclk0 = 1'b1; idle(5); mclk0 = 1'b0;
      check("basic_count5", 32'(grant_count), 32'd5);
      dma_done = 1'b1; tick(); dma_done = 1'b0;
      check("basic_drive_off", 32'(drive_AB), 32'd0);
      check("basic_still_halted", 32'(halt_n), 32'd0);
      dma_req = 1'b0;
      idle(2);
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      check("basic_halt_rel", 32'(halt_n), 32'd1);

      // Request rising together with pclk1 waits for the following pclk1.
      dma_req = 1'b1; pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      check("coinc_halt_high", 32'(halt_n), 32'd1);
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      check("coinc_halt_low", 32'(halt_n), 32'd0);
      dma_req = 1'b0; tick();
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      check("coinc_halt_rel", 32'(halt_n), 32'd1);

      // Aborted request.
      dma_req = 1'b1; idle(3); dma_req = 1'b0; idle(2);
      check("abort_halt", 32'(halt_n), 32'd1);
      check("abort_grant", 32'(dma_grant), 32'd0);

      // WSYNC stall.
      wsync = 1'b1; tick(); wsync = 1'b0;
      check("wsync_ready0", 32'(ready), 32'd0);
      idle(3);
      wsync = 1'b1; lrc = 1'b1; tick(); wsync = 1'b0; lrc = 1'b0;
      check("wsync_lrc_ready0", 32'(ready), 32'd0);
      lrc = 1'b1; tick(); lrc = 1'b0;
      check("lrc_ready1", 32'(ready), 32'd1);

      // maria_en drop mid-GRANT.
      enter_grant();
      wsync = 1'b1; tick(); wsync = 1'b0;
      maria_en = 1'b0; tick();
      check("dis_grant", 32'(dma_grant), 32'd0);
      check("dis_drive", 32'(drive_AB), 32'd0);
      check("dis_halt", 32'(halt_n), 32'd1);
      check("dis_ready", 32'(ready), 32'd1);
      pclk1 = 1'b1; tick(); pclk1 = 1'b0;
      pclk0 = 1'b1; tick(); pclk0 = 1'b0;
      check("dis_ignore_req", 32'(halt_n), 32'd1);
      maria_en = 1'b1; dma_req = 1'b0; idle(2);

      // grant_count saturation and lrc coincident with a counting mclk0.
      lrc = 1'b1; tick(); lrc = 1'b0;
      enter_grant();
      mclk0 = 1'b1; idle(600);
`ifndef MARIA_ARB_WATCHDOG_EN
      check("count_sat", 32'(grant_count), 32'd511);
      lrc = 1'b1; tick(); lrc = 1'b0;
      check("count_lrc_one", 32'(grant_count), 32'd1);
`endif
      leave_grant();

      // Watchdog stimulus: GRANT held for WDOG_LIMIT mclk0 strobes without dma_done.
      enter_grant();
      mclk0 = 1'b1; idle(WDOG_LIMIT);
`ifdef MARIA_ARB_WATCHDOG_EN
      check("wdog_pulse", 32'(wdog_timeout), 32'd1);
      check("wdog_drive", 32'(drive_AB), 32'd0);
`else
      check("wdog_none", 32'(wdog_timeout), 32'd0);
      check("wdog_hold", 32'(drive_AB), 32'd1);
`endif
      leave_grant();

      // Reset while the DMA owns the bus.
      enter_grant();
      reset = 1'b1; tick(); reset = 1'b0;
      check("rstg_grant", 32'(dma_grant), 32'd0);
      check("rstg_halt", 32'(halt_n), 32'd1);
      tick();

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         mclk0    = 1'($urandom % 2);
         pclk1    = ($urandom % 8) == 0;
         pclk0    = ($urandom % 8) == 0;
         dma_done = ($urandom % 20) == 0;
         wsync    = ($urandom % 30) == 0;
         lrc      = ($urandom % 40) == 0;
         maria_en = ($urandom % 64) != 0;
         reset    = ($urandom % 500) == 0;
         if (($urandom % 12) == 0) dma_req = ~dma_req;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
